pwm_capture: RTL
================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the pwm generator: measures an incoming PWM waveform.
//  Synchronises and glitch-filters PWM_IN, counts period and high time edge-to-edge,
//  and converts the ratio to a duty cycle via a sequential divider.
//  Sits at a board input or in loopback from PWM_OUT for self-check; flags stuck lines.
// PARAMETERS
//  CNT_W      20   width of period/high counters; saturation value = 2**CNT_W-1
//  FILT_LEN   4    cycles a new synced level must persist before it is accepted
//  DUTY_STEPS 100  full-scale duty value (100 = percent)
//  DUTY_W     7    DUTY_CYCLE width; 2**DUTY_W > DUTY_STEPS
// PORTS
//  clk         in   1       system clock, all logic on posedge
//  rst         in   1       synchronous reset, active-low
//  PWM_IN      in   1       asynchronous PWM input
//  PERIOD_CNT  out  CNT_W   last measured period, clk cycles
//  HIGH_CNT    out  CNT_W   last measured high time, clk cycles
//  DUTY_CYCLE  out  DUTY_W  floor(HIGH_CNT*DUTY_STEPS/PERIOD_CNT)
//  meas_valid  out  1       1-cycle pulse: outputs/flags just updated
//  stuck_high  out  1       no rising edge for 2**CNT_W-1 cycles, line high
//  stuck_low   out  1       same, line low
//  overrun     out  1       1-cycle pulse: rising edge arrived while divider busy
// BEHAVIOUR
//  Reset (rst==0 at posedge): all outputs 0; sync FFs, filter level, counters 0;
//   FSM -> IDLE, divider idle. Reset mid-measurement/mid-division discards work, no pulse.
//  Input path: 2-FF sync; filt level flips only after synced input differs from it
//   for FILT_LEN consecutive cycles. PWM_IN edge -> filt edge: 2+FILT_LEN cycles.
//   Pulses shorter than FILT_LEN cycles are ignored.
//  rise = filt 0->1 this cycle. Counter FSM: IDLE, MEAS.
//   IDLE: on rise -> MEAS, per_cnt=1, hi_cnt=1. No output (first edge is partial).
//   MEAS: per_cnt+1 each cycle; hi_cnt+1 when filt==1. On rise: snapshot
//    (per_cnt,hi_cnt) to divider, reload both to 1, stay MEAS.
//    Example: high 30 / low 70 -> snapshot per=100, hi=30.
//   Timeout: per_cnt reaching 2**CNT_W-1 in MEAS -> next cycle: if filt==1:
//    stuck_high=1, DUTY_CYCLE=DUTY_STEPS, HIGH_CNT=PERIOD_CNT=2**CNT_W-1;
//    else stuck_low=1, DUTY_CYCLE=0, HIGH_CNT=0, PERIOD_CNT=2**CNT_W-1;
//    meas_valid pulse; FSM -> IDLE. Any running division is aborted.
//  Divider: restoring, numerator hi*DUTY_STEPS, denominator per, one quotient bit
//   per cycle, DUTY_W iterations, truncating. Counters keep running during division.
//   Completion: PERIOD_CNT, HIGH_CNT, DUTY_CYCLE updated together, stuck flags
//   cleared, meas_valid=1 that cycle: DUTY_W+1 cycles after the snapshot rise.
//  Overrun: rise while divider busy -> that snapshot dropped, overrun pulse,
//   counters still reload, current division completes normally.
//  hi==per (min filtered period 2*FILT_LEN > 0, never divides by 0) -> DUTY=DUTY_STEPS.
//  Outputs hold between meas_valid pulses; stuck flags mutually exclusive.
// TESTING  (FILT_LEN=4, DUTY_STEPS=100, DUTY_W=7, CNT_W=20 unless noted)
//  1 rst=0 10 cycles, PWM_IN=1 -> all outputs 0, no meas_valid; release, hold PWM_IN=0
//    200 cycles -> still all 0.
//  2 PWM_IN high 30/low 70, 5 periods -> one meas_valid per period from the 2nd rise;
//    PERIOD_CNT=100, HIGH_CNT=30, DUTY_CYCLE=30; pulse 8 cycles after filtered rise.
//  3 high 10/low 20 -> PERIOD_CNT=30, HIGH_CNT=10, DUTY_CYCLE=33 (truncation).
//  4 2-cycle glitches inside low phase of case 2 -> results unchanged (100/30/30).
//  5 CNT_W=8: toggle then hold high -> 255 cycles after last rise: stuck_high=1,
//    DUTY_CYCLE=100, meas_valid; resume 30/70 -> after 2nd rise stuck_high=0, DUTY=30.
//  6 FILT_LEN=2, high 2/low 2 -> overrun pulses on alternating rises; every reported
//    result PERIOD_CNT=4, HIGH_CNT=2, DUTY_CYCLE=50; rst=0 mid-division -> outputs 0.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM receiver: synchronises and glitch-filters PWM_IN, measures period and high time
// between filtered rising edges, and derives the duty cycle with a restoring divider.
module pwm_capture #(
  parameter int CNT_W      = 20,
  parameter int FILT_LEN   = 4,
  parameter int DUTY_STEPS = 100,
  parameter int DUTY_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PWM_IN,
  output logic [CNT_W-1:0]  PERIOD_CNT,
  output logic [CNT_W-1:0]  HIGH_CNT,
  output logic [DUTY_W-1:0] DUTY_CYCLE,
  output logic              meas_valid,
  output logic              stuck_high,
  output logic              stuck_low,
  output logic              overrun
);

  localparam int FC_W  = $clog2(FILT_LEN + 1);
  localparam int REM_W = CNT_W + DUTY_W;
  localparam int IT_W  = $clog2(DUTY_W + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [REM_W-1:0]  STEPS_EXT = REM_W'(DUTY_STEPS);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(DUTY_STEPS);
  localparam logic [IT_W-1:0]   IT_LAST   = IT_W'(DUTY_W - 1);
  localparam logic [FC_W-1:0]   FILT_LAST = FC_W'(FILT_LEN - 1);

  typedef enum logic {IDLE, MEAS} state_t;

  logic              sync1_q, sync2_q;
  logic              filt_q, filt_d, filt_prev_q;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic              div_busy_q, div_busy_d;
  logic [REM_W-1:0]  div_rem_q, div_rem_d, div_den_q, div_den_d;
  logic [DUTY_W-1:0] div_quo_q, div_quo_d;
  logic [IT_W-1:0]   div_it_q, div_it_d;
  logic [CNT_W-1:0]  div_per_q, div_per_d, div_hi_q, div_hi_d;
  logic [CNT_W-1:0]  per_out_q, per_out_d, hi_out_q, hi_out_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d, sh_q, sh_d, sl_q, sl_d, ovr_q, ovr_d;
  logic              rise;
  logic              div_ge;
  logic [DUTY_W-1:0] quo_next;

  // A level change is accepted only after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FILT_LAST) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  assign rise     = filt_q & ~filt_prev_q;
  assign div_ge   = (div_rem_q >= div_den_q);
  assign quo_next = (div_quo_q << 1) | DUTY_W'(div_ge);

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    hi_cnt_d   = hi_cnt_q;
    div_busy_d = div_busy_q;
    div_rem_d  = div_rem_q;
    div_den_d  = div_den_q;
    div_quo_d  = div_quo_q;
    div_it_d   = div_it_q;
    div_per_d  = div_per_q;
    div_hi_d   = div_hi_q;
    per_out_d  = per_out_q;
    hi_out_d   = hi_out_q;
    duty_d     = duty_q;
    sh_d       = sh_q;
    sl_d       = sl_q;
    valid_d    = 1'b0;
    ovr_d      = 1'b0;

    // Shifted-divisor restoring division, MSB of the quotient first.
    if (div_busy_q) begin
      div_rem_d = div_ge ? (div_rem_q - div_den_q) : div_rem_q;
      div_den_d = div_den_q >> 1;
      div_quo_d = quo_next;
      div_it_d  = div_it_q + IT_W'(1);
      if (div_it_q == IT_LAST) begin
        div_busy_d = 1'b0;
        per_out_d  = div_per_q;
        hi_out_d   = div_hi_q;
        duty_d     = quo_next;
        sh_d       = 1'b0;
        sl_d       = 1'b0;
        valid_d    = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = MEAS;
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
        end
      end
      MEAS: begin
        per_cnt_d = per_cnt_q + CNT_ONE;
        hi_cnt_d  = hi_cnt_q + CNT_W'(filt_q);
        if (rise) begin
          per_cnt_d = CNT_ONE;
          hi_cnt_d  = CNT_ONE;
          if (div_busy_q) begin
            ovr_d = 1'b1;
          end else begin
            div_busy_d = 1'b1;
            div_rem_d  = REM_W'(hi_cnt_q) * STEPS_EXT;
            div_den_d  = REM_W'(per_cnt_q) << (DUTY_W - 1);
            div_quo_d  = '0;
            div_it_d   = '0;
            div_per_d  = per_cnt_q;
            div_hi_d   = hi_cnt_q;
          end
        end else if (per_cnt_q == CNT_MAX) begin
          // No edge for a full counter range: report the stuck level, drop any division.
          state_d    = IDLE;
          div_busy_d = 1'b0;
          per_out_d  = CNT_MAX;
          hi_out_d   = filt_q ? CNT_MAX : '0;
          duty_d     = filt_q ? DUTY_FULL : '0;
          sh_d       = filt_q;
          sl_d       = ~filt_q;
          valid_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
      state_q     <= IDLE;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      div_busy_q  <= 1'b0;
      div_rem_q   <= '0;
      div_den_q   <= '0;
      div_quo_q   <= '0;
      div_it_q    <= '0;
      div_per_q   <= '0;
      div_hi_q    <= '0;
      per_out_q   <= '0;
      hi_out_q    <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      sh_q        <= 1'b0;
      sl_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync1_q     <= PWM_IN;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      div_busy_q  <= div_busy_d;
      div_rem_q   <= div_rem_d;
      div_den_q   <= div_den_d;
      div_quo_q   <= div_quo_d;
      div_it_q    <= div_it_d;
      div_per_q   <= div_per_d;
      div_hi_q    <= div_hi_d;
      per_out_q   <= per_out_d;
      hi_out_q    <= hi_out_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      sh_q        <= sh_d;
      sl_q        <= sl_d;
      ovr_q       <= ovr_d;
    end
  end

  assign PERIOD_CNT = per_out_q;
  assign HIGH_CNT   = hi_out_q;
  assign DUTY_CYCLE = duty_q;
  assign meas_valid = valid_q;
  assign stuck_high = sh_q;
  assign stuck_low  = sl_q;
  assign overrun    = ovr_q;

endmodule
